// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver that packs every four good bytes into a little-endian word.
// Words are queued in a small FIFO and handed out one per request.
module uart_word_receiver #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int IBUF_SIZE_WIDTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        recv_enable,
    output logic [31:0] recv_data,
    output logic        recv_ready,
    output logic        overflow,
    output logic        frame_err
);

    localparam int TW    = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int AW    = IBUF_SIZE_WIDTH;
    localparam int DEPTH = 2 ** IBUF_SIZE_WIDTH;

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rxd_m;
    logic          rxd_s;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic          expired;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          byte_valid;
    logic [7:0]    byte_q;

    logic [1:0]    bc;
    logic [23:0]   word_lo;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          full;
    logic          word_done;
    logic          push;
    logic          pop;
    logic          pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign expired = (timer == '0);

    // Bit-timing FSM: samples land mid-bit because START waits half a bit first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_q     <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state <= S_START;
                        timer <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (expired) begin
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            timer   <= BIT_LOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                S_DATA: begin
                    if (expired) begin
                        shift[bit_idx] <= rxd_s;
                        timer          <= BIT_LOAD;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                S_STOP: begin
                    if (expired) begin
                        state <= S_IDLE;
                        if (rxd_s) begin
                            byte_valid <= 1'b1;
                            byte_q     <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign word_done = byte_valid && (bc == 2'd3);
    assign push      = word_done && !full;
    assign pop       = pending && !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= {byte_q, word_lo};
    end

    // A dropped word still wraps bc so the next word starts cleanly at byte 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            bc         <= '0;
            word_lo    <= '0;
            wptr       <= '0;
            rptr       <= '0;
            overflow   <= 1'b0;
            pending    <= 1'b0;
            recv_ready <= 1'b1;
            recv_data  <= '0;
        end else begin
            if (byte_valid) begin
                if (bc == 2'd3) begin
                    bc <= '0;
                    if (full)
                        overflow <= 1'b1;
                end else begin
                    case (bc)
                        2'd0:    word_lo[7:0]   <= byte_q;
                        2'd1:    word_lo[15:8]  <= byte_q;
                        default: word_lo[23:16] <= byte_q;
                    endcase
                    bc <= bc + 2'd1;
                end
            end

            if (push)
                wptr <= wptr + PTR_ONE;

            if (pop) begin
                recv_data <= mem[rptr[AW-1:0]];
                rptr      <= rptr + PTR_ONE;
            end

            if (!pending) begin
                if (recv_enable) begin
                    pending    <= 1'b1;
                    recv_ready <= 1'b0;
                end
            end else if (!empty) begin
                pending    <= 1'b0;
                recv_ready <= 1'b1;
            end
        end
    end

endmodule
